burst_rr_arbiter: RTL and testbench

- Shares one burst-grant resource among NUM_REQ requesters.
- Each requester asks for a burst of 1..8 consecutive grant cycles.
- The arbiter picks one requester round-robin and drives that requester's gnt for the requested number of cycles, flagging the final cycle with last.
- It sits in front of the grant-burst datapath and re-arbitrates in a burst's last cycle, so consecutive bursts from different owners have no bubble between them.

---
 rtl/burst_rr_arbiter_if.sv | 18 +
 rtl/burst_rr_arbiter.sv | 90 +++++++++
 tb/tb_burst_rr_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/burst_rr_arbiter_if.sv
// Request/grant bundle between NUM_REQ requesters and the burst round-robin arbiter.
// The master modport is the requester side and the slave modport is the arbiter side.
interface burst_rr_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int LEN_W   = 3,
   parameter int IDX_W   = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*LEN_W-1:0] len;
   logic [NUM_REQ-1:0]       req_ack;
   logic [NUM_REQ-1:0]       gnt;
   logic                     last;
   logic                     busy;
   logic [IDX_W-1:0]         owner;

   modport master (output req, len, input req_ack, gnt, last, busy, owner);
   modport slave  (input req, len, output req_ack, gnt, last, busy, owner);
endinterface

// File: rtl/burst_rr_arbiter.sv
// Round-robin arbiter granting 1..2**LEN_W-cycle bursts; req_ack is same-cycle and gnt starts next cycle.
// There is no backpressure: requesters hold req until acked, and re-arbitration in the last cycle avoids bubbles.
module burst_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int LEN_W   = 3,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic              clk,
   input  logic              reset,
   burst_rr_arbiter_if.slave arb
);
   typedef enum logic {IDLE, ACTIVE} state_e;

   state_e           state_q, state_d;
   logic [LEN_W:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0] owner_q, owner_d;

   logic             arb_cycle;
   logic             found;
   logic [IDX_W-1:0] winner;
   logic [IDX_W-1:0] idx_v;
   logic [LEN_W-1:0] win_len;
   int               idx;

   assign arb_cycle = (state_q == IDLE) || (cnt_q == (LEN_W+1)'(1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rr_ptr_q <= '0;
         owner_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
      end
   end

   always_comb begin : next_state
      found    = 1'b0;
      winner   = '0;
      idx      = 0;
      idx_v    = '0;
      win_len  = '0;
      state_d  = state_q;
      cnt_d    = cnt_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;

      // First requester at or after rr_ptr, wrapping around.
      for (int k = 0; k < NUM_REQ; k++) begin
         idx   = (int'(rr_ptr_q) + k) % NUM_REQ;
         idx_v = IDX_W'(idx);
         if (!found && arb.req[idx_v]) begin
            found  = 1'b1;
            winner = idx_v;
         end
      end

      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner == IDX_W'(i)) win_len = arb.len[i*LEN_W +: LEN_W];
      end

      if (arb_cycle) begin
         if (found) begin
            state_d  = ACTIVE;
            owner_d  = winner;
            cnt_d    = (win_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, win_len};
            rr_ptr_d = (winner == IDX_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
         end else begin
            state_d = IDLE;
            cnt_d   = '0;
            owner_d = '0;
         end
      end else begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_comb begin : outputs
      arb.busy    = (state_q == ACTIVE);
      arb.last    = arb.busy && (cnt_q == (LEN_W+1)'(1));
      arb.gnt     = arb.busy ? (NUM_REQ'(1) << owner_q) : '0;
      arb.owner   = arb.busy ? owner_q : '0;
      arb.req_ack = (arb_cycle && found) ? (NUM_REQ'(1) << winner) : '0;
   end
endmodule

// File: tb/tb_burst_rr_arbiter.sv
// Directed bench for burst_rr_arbiter: hand-computed cycle-by-cycle expectations.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_burst_rr_arbiter;
   logic clk;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   burst_rr_arbiter_if #(.NUM_REQ(4), .LEN_W(3)) bus ();

   burst_rr_arbiter #(.NUM_REQ(4), .LEN_W(3)) dut (
      .clk   (clk),
      .reset (reset),
      .arb   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] a, input logic [3:0] g,
                          input logic l, input logic b, input logic [1:0] o);
      chk({tag, ".req_ack"}, 8'(bus.req_ack), 8'(a));
      chk({tag, ".gnt"},     8'(bus.gnt),     8'(g));
      chk({tag, ".last"},    8'(bus.last),    8'(l));
      chk({tag, ".busy"},    8'(bus.busy),    8'(b));
      chk({tag, ".owner"},   8'(bus.owner),   8'(o));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic set_len(input int i, input logic [2:0] v);
      bus.len[i*3 +: 3] = v;
   endtask

   initial begin
      logic [3:0] one;
      one     = 4'b0001;
      reset   = 1'b1;
      bus.req = '0;
      bus.len = '0;
      repeat (2) @(posedge clk);
      sample();
      chk_all("reset", 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0);
      tick();
      reset = 1'b0;

      // Single request, len=3, rr_ptr=0
      bus.req = 4'b0010; set_len(1, 3'd3);
      sample(); chk_all("single.c0", 4'b0010, 4'b0000, 1'b0, 1'b0, 2'd0);
      tick(); bus.req = '0;
      sample(); chk_all("single.c1", 4'b0000, 4'b0010, 1'b0, 1'b1, 2'd1);
      tick(); sample(); chk_all("single.c2", 4'b0000, 4'b0010, 1'b0, 1'b1, 2'd1);
      tick(); sample(); chk_all("single.c3", 4'b0000, 4'b0010, 1'b1, 1'b1, 2'd1);
      tick(); sample(); chk_all("single.c4", 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0);

      // len=0 means 8 cycles; rr_ptr=2 so search wraps 2,3,0
      tick(); bus.req = 4'b0001; set_len(0, 3'd0);
      sample(); chk_all("len0.c0", 4'b0001, 4'b0000, 1'b0, 1'b0, 2'd0);
      tick(); bus.req = '0;
      for (int c = 1; c <= 8; c++) begin
         sample(); chk_all($sformatf("len0.c%0d", c), 4'b0000, 4'b0001, (c == 8), 1'b1, 2'd0);
         tick();
      end
      sample(); chk_all("len0.end", 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0);

      // len=1: single grant cycle with last
      tick(); bus.req = 4'b0010; set_len(1, 3'd1);
      sample(); chk_all("len1.c0", 4'b0010, 4'b0000, 1'b0, 1'b0, 2'd0);
      tick(); bus.req = '0;
      sample(); chk_all("len1.c1", 4'b0000, 4'b0010, 1'b1, 1'b1, 2'd1);
      tick(); sample(); chk_all("len1.c2", 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0);

      // Bring rr_ptr back to 0 via a 1-cycle burst from requester 3
      tick(); bus.req = 4'b1000; set_len(3, 3'd1);
      sample(); chk_all("wrap.c0", 4'b1000, 4'b0000, 1'b0, 1'b0, 2'd0);
      tick(); bus.req = '0;
      sample(); chk_all("wrap.c1", 4'b0000, 4'b1000, 1'b1, 1'b1, 2'd3);

      // Simultaneous req[0], req[2], len=2 each
      tick(); bus.req = 4'b0101; set_len(0, 3'd2); set_len(2, 3'd2);
      sample(); chk_all("simul.c0", 4'b0001, 4'b0000, 1'b0, 1'b0, 2'd0);
      tick(); bus.req = 4'b0100;
      sample(); chk_all("simul.c1", 4'b0000, 4'b0001, 1'b0, 1'b1, 2'd0);
      tick(); sample(); chk_all("simul.c2", 4'b0100, 4'b0001, 1'b1, 1'b1, 2'd0);
      tick(); bus.req = '0;
      sample(); chk_all("simul.c3", 4'b0000, 4'b0100, 1'b0, 1'b1, 2'd2);
      tick(); sample(); chk_all("simul.c4", 4'b0000, 4'b0100, 1'b1, 1'b1, 2'd2);
      tick(); sample(); chk_all("simul.c5", 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0);

      // rr_ptr=3: one burst from 3 returns it to 0
      tick(); bus.req = 4'b1000;
      sample(); chk_all("wrap2.c0", 4'b1000, 4'b0000, 1'b0, 1'b0, 2'd0);
      tick(); bus.req = '0;
      sample(); chk_all("wrap2.c1", 4'b0000, 4'b1000, 1'b1, 1'b1, 2'd3);

      // Fairness: all requests held, len=1
      tick(); bus.req = 4'b1111;
      for (int i = 0; i < 4; i++) set_len(i, 3'd1);
      for (int c = 0; c <= 6; c++) begin
         sample();
         chk_all($sformatf("fair.c%0d", c), one << (c % 4),
                 (c == 0) ? 4'b0000 : (one << ((c - 1) % 4)),
                 (c != 0), (c != 0), (c == 0) ? 2'd0 : 2'((c - 1) % 4));
         tick();
      end
      bus.req = '0;
      sample(); chk_all("fair.c7", 4'b0000, 4'b0100, 1'b1, 1'b1, 2'd2);
      tick(); sample(); chk_all("fair.c8", 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0);

      // Reset in cycle 2 of a len=5 burst owned by requester 3 (rr_ptr=3)
      tick(); bus.req = 4'b1000; set_len(3, 3'd5);
      sample(); chk_all("rst.c0", 4'b1000, 4'b0000, 1'b0, 1'b0, 2'd0);
      tick(); bus.req = '0;
      sample(); chk_all("rst.c1", 4'b0000, 4'b1000, 1'b0, 1'b1, 2'd3);
      tick();
      #2 reset = 1'b1;
      #1 chk_all("rst.async", 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0);
      bus.req = 4'b0010; set_len(1, 3'd2);
      tick(); reset = 1'b0;
      sample(); chk_all("rst.after", 4'b0010, 4'b0000, 1'b0, 1'b0, 2'd0);
      tick(); bus.req = '0;
      sample(); chk_all("rst2.c1", 4'b0000, 4'b0010, 1'b0, 1'b1, 2'd1);
      // Second reset with rr_ptr=2: search must restart from 0, not 2
      #1 reset = 1'b1;
      bus.req = 4'b1001; set_len(0, 3'd1);
      tick(); reset = 1'b0;
      sample(); chk_all("rst2.ptr", 4'b0001, 4'b0000, 1'b0, 1'b0, 2'd0);
      tick(); bus.req = '0;
      sample(); chk_all("rst2.c1b", 4'b0000, 4'b0001, 1'b1, 1'b1, 2'd0);

      // len change mid-burst: 4 -> 7 has no effect until next ack
      tick(); bus.req = 4'b0100; set_len(2, 3'd4);
      sample(); chk_all("lenchg.c0", 4'b0100, 4'b0000, 1'b0, 1'b0, 2'd0);
      tick(); bus.req = '0; set_len(2, 3'd7);
      for (int c = 1; c <= 4; c++) begin
         sample(); chk_all($sformatf("lenchg.c%0d", c), 4'b0000, 4'b0100, (c == 4), 1'b1, 2'd2);
         tick();
      end
      sample(); chk_all("lenchg.end", 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0);
      tick(); bus.req = 4'b0100;
      sample(); chk_all("lennew.c0", 4'b0100, 4'b0000, 1'b0, 1'b0, 2'd0);
      tick(); bus.req = '0;
      for (int c = 1; c <= 7; c++) begin
         sample(); chk_all($sformatf("lennew.c%0d", c), 4'b0000, 4'b0100, (c == 7), 1'b1, 2'd2);
         tick();
      end
      sample(); chk_all("lennew.end", 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
